// File: rtl/down_counter.sv
// -----------------------------------------------------------------------------
// down_counter
//
// Loadable synchronous down counter / timer. A load captures a start value and
// (if non-zero) enters RUN. Each enabled clock in RUN decrements the count. The
// edge that takes the count from 1 to its next value is the terminal edge: it
// raises tc for exactly one cycle and either stops at 0 (one-shot) or reloads
// the stored start value (auto-reload, a periodic tick generator).
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   clr          synchronous active-low reset, highest priority
//   load         load strobe, captures load_val (second priority)
//   load_val     start / reload value, WIDTH bits
//   en           count enable, only meaningful in RUN
//   auto_reload  1 = reload at terminal count, 0 = stop at 0 (sampled at the
//                terminal edge only)
//   Q            current count (registered)
//   busy         high while in RUN (registered)
//   tc           terminal-count pulse, one cycle wide (registered)
// -----------------------------------------------------------------------------
module down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]       state_r;
  logic [0:0]       state_nxt_s;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_nxt_s;
  logic [WIDTH-1:0] reload_r;
  logic [WIDTH-1:0] reload_nxt_s;
  logic             busy_r;
  logic             tc_r;
  logic             tc_nxt_s;
  logic             at_one_s;

  // Terminal edge happens on the enabled clock where the count sits at 1;
  // 0 is never held in RUN, so the count can never wrap below zero.
  assign at_one_s = (q_r == CNT_ONE);

  // Next-state decode: load beats counting, counting only in RUN with en.
  always_comb begin
    state_nxt_s  = state_r;
    q_nxt_s      = q_r;
    reload_nxt_s = reload_r;
    tc_nxt_s     = 1'b0;

    if (load) begin
      // A load restarts everything and swallows any tc this edge would give.
      q_nxt_s      = load_val;
      reload_nxt_s = load_val;
      if (load_val != CNT_ZERO) begin
        state_nxt_s = RUN;
      end else begin
        state_nxt_s = IDLE;
      end
    end else begin
      case (state_r)
        IDLE: begin
          // en and auto_reload are don't-cares here; hold everything.
          state_nxt_s = IDLE;
        end
        RUN: begin
          if (en) begin
            if (at_one_s) begin
              tc_nxt_s = 1'b1;
              if (auto_reload) begin
                // Period is reload_r enabled cycles; reload_r==1 keeps Q at 1
                // and produces a tc on every enabled cycle.
                q_nxt_s     = reload_r;
                state_nxt_s = RUN;
              end else begin
                q_nxt_s     = CNT_ZERO;
                state_nxt_s = IDLE;
              end
            end else begin
              q_nxt_s = q_r - CNT_ONE;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          // Unreachable with a 1-bit state, but recover to a safe idle.
          state_nxt_s = IDLE;
          q_nxt_s     = CNT_ZERO;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!clr) begin
      state_r  <= IDLE;
      q_r      <= CNT_ZERO;
      reload_r <= CNT_ZERO;
      busy_r   <= 1'b0;
      tc_r     <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      q_r      <= q_nxt_s;
      reload_r <= reload_nxt_s;
      // busy is registered alongside state so it always equals (state==RUN).
      busy_r   <= (state_nxt_s == RUN);
      tc_r     <= tc_nxt_s;
    end
  end

  assign Q    = q_r;
  assign busy = busy_r;
  assign tc   = tc_r;

endmodule

// File: tb/tb_down_counter.sv
// -----------------------------------------------------------------------------
// tb_down_counter
//
// Directed bench for down_counter (WIDTH=4). A table of per-cycle vectors
// {inputs, expected Q/busy/tc} is applied one rising edge per row, followed by
// hand-written sequences for the full-range count and a clear during RUN.
// -----------------------------------------------------------------------------
module tb_down_counter;

  localparam int WIDTH = 4;

  logic             clk;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             auto_reload;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             tc;

  int checks;
  int errors;

  typedef struct {
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic             auto_reload;
    logic [WIDTH-1:0] exp_q;
    logic             exp_busy;
    logic             exp_tc;
    string            name;
  } vec_t;

  vec_t vecs[$];

  down_counter #(.WIDTH(WIDTH)) dut (
    .clk         (clk),
    .clr         (clr),
    .load        (load),
    .load_val    (load_val),
    .en          (en),
    .auto_reload (auto_reload),
    .Q           (Q),
    .busy        (busy),
    .tc          (tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input logic c, input logic l, input logic [WIDTH-1:0] v,
                      input logic e, input logic a, input logic [WIDTH-1:0] eq,
                      input logic eb, input logic et, input string nm);
    vec_t r;
    r.clr = c; r.load = l; r.load_val = v; r.en = e; r.auto_reload = a;
    r.exp_q = eq; r.exp_busy = eb; r.exp_tc = et; r.name = nm;
    vecs.push_back(r);
  endtask

  task automatic check(input string nm, input int idx, input logic [WIDTH-1:0] aq,
                       input logic ab, input logic at, input logic [WIDTH-1:0] eq,
                       input logic eb, input logic et);
    checks = checks + 1;
    if (aq !== eq || ab !== eb || at !== et) begin
      errors = errors + 1;
      $display("FAIL %s[%0d]: got Q=%0d busy=%b tc=%b, expected Q=%0d busy=%b tc=%b",
               nm, idx, aq, ab, at, eq, eb, et);
    end
  endtask

  task automatic step(input logic c, input logic l, input logic [WIDTH-1:0] v,
                      input logic e, input logic a);
    clr = c; load = l; load_val = v; en = e; auto_reload = a;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clr = 1'b0; load = 1'b0; load_val = 4'd0; en = 1'b0; auto_reload = 1'b0;

    //    clr   load  val    en    ar    Q      busy  tc    name
    // reset dominates load/en
    push(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "reset");
    push(1'b0, 1'b1, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "reset");
    push(1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "post_reset");
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, "post_reset");
    // one-shot from 5
    push(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd5, 1'b1, 1'b0, "oneshot");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, "oneshot");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, "oneshot");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, "oneshot");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, "oneshot");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "oneshot_tc");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "idle_ignores_en");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "idle_ignores_en");
    // enable gating
    push(1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, "gate");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, "gate");
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, "gate_hold");
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, "gate_hold");
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 1'b1, 1'b0, "gate_hold");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, "gate");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, "gate");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "gate_tc");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "gate_after");
    // auto-reload period 3, then drop auto_reload
    push(1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, "auto");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, "auto");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, "auto");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, "auto_tc");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, "auto");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, "auto");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, "auto_tc");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, "auto_drop");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, "auto_drop");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "auto_drop_tc");
    // load collision at the terminal edge
    push(1'b1, 1'b1, 4'd2, 1'b0, 1'b0, 4'd2, 1'b1, 1'b0, "collide");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 1'b0, "collide");
    push(1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 4'd6, 1'b1, 1'b0, "collide_load");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, "collide_resume");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd4, 1'b1, 1'b0, "collide_resume");
    // load of zero from RUN goes idle with no tc
    push(1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, "load_zero");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "load_zero");
    // reload value 1: tc on every enabled cycle, Q held at 1
    push(1'b1, 1'b1, 4'd1, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, "reload1");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, "reload1_tc");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b1, "reload1_tc");
    push(1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd1, 1'b1, 1'b0, "reload1_hold");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, "reload1_stop");
    // clear at the terminal edge cancels the tc
    push(1'b1, 1'b1, 4'd2, 1'b0, 1'b1, 4'd2, 1'b1, 1'b0, "clr_tc");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, "clr_tc");
    push(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "clr_tc_cancel");
    push(1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b0, 1'b0, "clr_tc_after");

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].clr, vecs[i].load, vecs[i].load_val, vecs[i].en, vecs[i].auto_reload);
      check(vecs[i].name, i, Q, busy, tc, vecs[i].exp_q, vecs[i].exp_busy, vecs[i].exp_tc);
    end

    // Full-range count: 15 enabled cycles from load to tc, Q falling by one.
    begin
      int k;
      logic [WIDTH-1:0] exp_q;
      bit seen_tc;
      step(1'b1, 1'b1, 4'd15, 1'b1, 1'b0);
      check("max_load", 0, Q, busy, tc, 4'd15, 1'b1, 1'b0);
      seen_tc = 1'b0;
      k = 0;
      while (!seen_tc && k < 40) begin
        k = k + 1;
        step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
        exp_q = (k >= 15) ? 4'd0 : 4'(15 - k);
        check("max_count", k, Q, busy, tc, exp_q, (k < 15), (k == 15));
        seen_tc = (tc === 1'b1);
      end
      checks = checks + 1;
      if (k != 15) begin
        errors = errors + 1;
        $display("FAIL max_cycles_to_tc: got %0d enabled cycles, expected 15", k);
      end
    end

    // Clear asserted with Q==2 in RUN.
    step(1'b1, 1'b1, 4'd4, 1'b1, 1'b0);
    check("clr_mid", 0, Q, busy, tc, 4'd4, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b0);
    check("clr_mid", 1, Q, busy, tc, 4'd2, 1'b1, 1'b0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
    check("clr_mid", 2, Q, busy, tc, 4'd0, 1'b0, 1'b0);
    // After clear, counting does not resume (reload value was cleared too).
    step(1'b1, 1'b0, 4'd0, 1'b1, 1'b1);
    check("clr_mid", 3, Q, busy, tc, 4'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/down_counter.md
Name: down_counter

Overview:
Loadable synchronous down counter/timer. It is the count-down companion to the team's 4-bit up counter. It is loaded with a start value, decrements once per enabled clock, and flags terminal count with a one-cycle pulse. An optional auto-reload mode turns it into a periodic tick generator for use by other blocks in the design.

Parameters:
WIDTH, 4, counter and load-value width in bits (legal range 2..16)

Ports:
clk  input  1  system clock; all state updates on the rising edge
clr  input  1  synchronous active-low reset; sampled on the rising edge of clk
load  input  1  load strobe; captures load_val at the rising edge
load_val  input  WIDTH  start/reload value
en  input  1  count enable; decrement when high in RUN
auto_reload  input  1  1 = reload from the stored value at terminal count; 0 = stop at 0
Q  output  WIDTH  current count (registered)
busy  output  1  high while in RUN
tc  output  1  terminal-count pulse, high for exactly one cycle

Behaviour:
- Reset: the port is clr; it is synchronous and active-low.
  - clr==0 at a rising edge: Q=0, busy=0, tc=0, internal reload_reg=0, state=IDLE.
  - No asynchronous path.
  - clr has priority over every other input.
- States: IDLE, RUN. busy is registered and equals (state==RUN).
- Every output is registered. Inputs sampled at edge N are visible on the outputs after edge N.
- Priority at each edge: clr, then load, then count.
- Load (any state):
  - Q<=load_val and reload_reg<=load_val.
  - load_val!=0: state<=RUN.
  - load_val==0: state<=IDLE.
  - tc<=0.
  - A load in RUN restarts the count immediately and suppresses any tc that edge would otherwise have produced.
- IDLE:
  - en and auto_reload are ignored.
  - Q holds its value.
  - tc<=0.
- RUN, en==0: Q, state and reload_reg hold; tc<=0.
- RUN, en==1, Q>1: Q<=Q-1; tc<=0.
- RUN, en==1, Q==1 (terminal edge): tc<=1 for exactly one cycle.
  - auto_reload==0: Q<=0, state<=IDLE. busy falls on the same edge tc rises.
  - auto_reload==1: Q<=reload_reg, state stays RUN.
  - auto_reload is sampled only at the terminal edge.
- The period in auto-reload mode is reload_reg enabled cycles. reload_reg==1 gives a tc on every enabled cycle, with Q held at 1.
- Q never wraps below 0. No decrement occurs from 0, because 0 is never held in RUN.
- clr low mid-run: the next edge forces the reset values; an in-flight tc is cancelled.
- Arithmetic is unsigned, modulo-free. Maximum load value is 2^WIDTH-1.

Test Plan:
- Reset: hold clr=0 for 2 cycles with load=1, load_val=9, en=1 -> Q=0, busy=0, tc=0 throughout. clr=1 with load=0 -> outputs stay 0.
- One-shot: load 5 for one cycle, then en=1 -> Q sequence 5,4,3,2,1,0 on successive edges.
  - tc=1 only in the cycle Q==0.
  - busy=1 from the load edge until the Q==0 edge.
  - Q stays 0 afterwards; en is ignored in IDLE.
- Enable gating: load 4, en=1 for 1 cycle, en=0 for 3 cycles, then en=1 -> Q=4,3,3,3,3,2,1,0; a single tc pulse.
- Auto-reload: auto_reload=1, load 3, en=1 -> Q=3,2,1,3,2,1,3...
  - tc high in each cycle Q returns to 3, i.e. every 3 cycles.
  - busy stays 1.
  - Drop auto_reload -> the next terminal edge gives Q=0, busy=0.
- Load collision: in RUN with Q==1, en=1, load=1, load_val=6 -> Q=6, tc=0, busy=1. Counting resumes 5,4,...
- Boundaries:
  - load_val=0 -> Q=0, busy=0, no tc.
  - load 2^WIDTH-1 (15) with en=1 -> exactly 15 enabled cycles to tc.
  - Assert clr=0 when Q==2 in RUN -> next edge Q=0, busy=0, tc=0.
